// File: rtl/result_led_pager.sv
// Pages a snapshotted result bus and its flags onto an LED bank, one slice at a time.
// Supports manual page selection, timed auto-scan, hold/sample capture and a change pulse.
module result_led_pager #(
  parameter int DATA_W   = 32,
  parameter int LED_W    = 8,
  parameter int FLAG_W   = 2,
  parameter int SEL_W    = 3,
  parameter int SCAN_DIV = 50000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic [FLAG_W-1:0] flags_in,
  input  logic              hold,
  input  logic              sample,
  input  logic              mode,
  input  logic [SEL_W-1:0]  SW,
  output logic [LED_W-1:0]  LED,
  output logic [SEL_W-1:0]  page,
  output logic              changed
);

  localparam int NSLICE = (DATA_W + LED_W - 1) / LED_W;
  localparam int NPAGE  = NSLICE + 1;
  localparam int PAD_W  = NSLICE * LED_W;
  localparam int PRE_W  = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(SCAN_DIV - 1);
  localparam logic [SEL_W-1:0] PAGE_LAST = SEL_W'(NPAGE - 1);
  localparam logic [SEL_W-1:0] FLAG_PAGE = SEL_W'(NSLICE);

  logic [DATA_W-1:0] snap_data_q, snap_data_d;
  logic [FLAG_W-1:0] snap_flags_q, snap_flags_d;
  logic [SEL_W-1:0]  page_q, page_d;
  logic [PRE_W-1:0]  presc_q, presc_d;
  logic [LED_W-1:0]  led_q, led_d;
  logic              changed_q, changed_d;

  logic              ld;
  logic [PAD_W-1:0]  data_pad;

  assign ld       = !hold || sample;
  assign data_pad = PAD_W'(snap_data_q);

  always_comb begin
    snap_data_d  = snap_data_q;
    snap_flags_d = snap_flags_q;
    changed_d    = 1'b0;
    if (ld) begin
      snap_data_d  = data_in;
      snap_flags_d = flags_in;
      changed_d    = ({data_in, flags_in} != {snap_data_q, snap_flags_q});
    end
  end

  // Prescaler rests at zero in manual mode, so entering auto always starts a full period.
  always_comb begin
    presc_d = '0;
    page_d  = page_q;
    if (mode) begin
      if (presc_q == PRE_LAST) begin
        presc_d = '0;
        page_d  = (page_q >= PAGE_LAST) ? '0 : page_q + SEL_W'(1);
      end else begin
        presc_d = presc_q + PRE_W'(1);
      end
    end else begin
      page_d = SW;
    end
  end

  always_comb begin
    led_d = '0;
    for (int k = 0; k < NSLICE; k++) begin
      if (page_q == SEL_W'(k)) begin
        led_d = data_pad[k*LED_W +: LED_W];
      end
    end
    if (page_q == FLAG_PAGE) begin
      led_d = LED_W'(snap_flags_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      snap_data_q  <= '0;
      snap_flags_q <= '0;
      page_q       <= '0;
      presc_q      <= '0;
      led_q        <= '0;
      changed_q    <= 1'b0;
    end else begin
      snap_data_q  <= snap_data_d;
      snap_flags_q <= snap_flags_d;
      page_q       <= page_d;
      presc_q      <= presc_d;
      led_q        <= led_d;
      changed_q    <= changed_d;
    end
  end

  assign LED     = led_q;
  assign page    = page_q;
  assign changed = changed_q;

endmodule

// File: tb/tb_result_led_pager.sv
// Scoreboarded bench for result_led_pager: a behavioural model predicts LED/page/changed
// every cycle; a negedge monitor pops and compares. Directed checks cover the key scenarios.
module tb_result_led_pager;

  localparam int DATA_W = 32, LED_W = 8, FLAG_W = 2, SEL_W = 3, SCAN_DIV = 4;
  localparam int NSLICE = 4, NPAGE = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] data_in;
  logic [FLAG_W-1:0] flags_in;
  logic              hold, sample, mode;
  logic [SEL_W-1:0]  SW;
  logic [LED_W-1:0]  LED;
  logic [SEL_W-1:0]  page;
  logic              changed;

  int checks = 0;
  int failures = 0;

  result_led_pager #(
    .DATA_W(DATA_W), .LED_W(LED_W), .FLAG_W(FLAG_W), .SEL_W(SEL_W), .SCAN_DIV(SCAN_DIV)
  ) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .flags_in(flags_in), .hold(hold),
    .sample(sample), .mode(mode), .SW(SW), .LED(LED), .page(page), .changed(changed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: snapshot as plain values, page as an integer, scan timing as a tick count.
  logic [31:0] m_snap = '0;
  logic [1:0]  m_flags = '0;
  int          m_page = 0;
  int          m_tick = 0;
  logic [11:0] exp_q[$];

  function automatic logic [7:0] led_of(input int p, input logic [31:0] s, input logic [1:0] f);
    if (p < NSLICE) return 8'((s >> (8 * p)) & 32'hFF);
    if (p == NSLICE) return {6'b0, f};
    return 8'h00;
  endfunction

  always @(posedge clk) begin
    automatic logic [7:0] n_led = 8'h00;
    automatic bit         n_chg = 1'b0;
    automatic int         n_page = 0;
    automatic int         n_tick = 0;
    automatic logic [31:0] n_snap = 32'h0;
    automatic logic [1:0]  n_flags = 2'b00;
    if (!rst) begin
      n_led   = led_of(m_page, m_snap, m_flags);
      n_snap  = m_snap;
      n_flags = m_flags;
      if (!hold || sample) begin
        n_chg   = (data_in != m_snap) || (flags_in != m_flags);
        n_snap  = data_in;
        n_flags = flags_in;
      end
      if (mode) begin
        n_tick = (m_tick + 1) % SCAN_DIV;
        n_page = m_page;
        if (n_tick == 0) n_page = (m_page >= NPAGE - 1) ? 0 : m_page + 1;
      end else begin
        n_page = int'(SW);
      end
    end
    m_snap  <= n_snap;
    m_flags <= n_flags;
    m_page  <= n_page;
    m_tick  <= n_tick;
    exp_q.push_back({n_led, 3'(n_page), n_chg});
  end

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      automatic logic [11:0] e = exp_q.pop_front();
      chk("sb_led", 32'(LED), 32'(e[11:4]));
      chk("sb_page", 32'(page), 32'(e[3:1]));
      chk("sb_changed", 32'(changed), 32'(e[0]));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    automatic logic [7:0] man_exp[8] = '{8'h78, 8'h56, 8'h34, 8'h12, 8'h02, 8'h00, 8'h00, 8'h00};
    automatic bit found = 1'b0;

    rst = 1'b1; data_in = 32'hDEADBEEF; flags_in = 2'b10; hold = 1'b0; sample = 1'b0;
    mode = 1'b0; SW = '0;
    step(2);
    chk("rst_led", 32'(LED), 32'h0);
    chk("rst_page", 32'(page), 32'h0);
    chk("rst_changed", 32'(changed), 32'h0);
    rst = 1'b0;

    data_in = 32'h12345678;
    for (int s = 0; s < 8; s++) begin
      SW = 3'(s);
      step(2);
      chk($sformatf("manual_sw%0d", s), 32'(LED), 32'(man_exp[s]));
    end

    SW = 3'd0; hold = 1'b1;
    step(2);
    data_in = 32'hA5A5A5A5;
    step(3);
    chk("hold_led", 32'(LED), 32'h78);
    sample = 1'b1; step(1); sample = 1'b0;
    chk("sample_changed", 32'(changed), 32'h1);
    step(1);
    chk("sample_led", 32'(LED), 32'hA5);
    chk("sample_changed_clr", 32'(changed), 32'h0);
    sample = 1'b1; step(1); sample = 1'b0;
    chk("resample_changed", 32'(changed), 32'h0);

    step(1);
    mode = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step(1);
      if (i % 4 == 0) chk($sformatf("auto_page_%0d", i), 32'(page), 32'((i / 4) % NPAGE));
    end

    mode = 1'b0; SW = 3'd6;
    step(3);
    chk("sw6_led", 32'(LED), 32'h0);
    mode = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step(1);
      chk($sformatf("oor_led_%0d", i), 32'(LED), 32'h0);
      chk($sformatf("oor_page_%0d", i), 32'(page), (i == 4) ? 32'h0 : 32'h6);
    end
    step(1);
    chk("oor_wrap_led", 32'(LED), 32'hA5);
    data_in = 32'h0F1E2D3C; sample = 1'b1;
    step(1);
    sample = 1'b0;
    chk("hold_sample_changed", 32'(changed), 32'h1);

    for (int i = 0; i < 40 && !found; i++) begin
      if (m_page == 3 && m_tick == 2) found = 1'b1;
      else step(1);
    end
    chk("wait_page3", 32'(found), 32'h1);
    rst = 1'b1;
    step(1);
    chk("midscan_led", 32'(LED), 32'h0);
    chk("midscan_page", 32'(page), 32'h0);
    chk("midscan_changed", 32'(changed), 32'h0);
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step(1);
      chk($sformatf("restart_page_%0d", i), 32'(page), (i == 4) ? 32'h1 : 32'h0);
    end

    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 3) == 0) data_in = $urandom;
      flags_in = 2'($urandom_range(0, 3));
      hold     = ($urandom_range(0, 2) != 0);
      sample   = ($urandom_range(0, 7) == 0);
      SW       = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      rst      = ($urandom_range(0, 63) == 0);
      step(1);
    end
    rst = 1'b0;
    step(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
